// File: rtl/read_return_router.sv
`default_nettype none
// ============================================================================
//  Module      : read_return_router
//  Description : Routes returning read words to the requester port that
//                issued them, using an in-order FIFO of one-hot port tags.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_return_router #(
    parameter int DATA_WIDTH = 48,
    parameter int PORT_NUM   = 3,
    parameter int TAG_DEPTH  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_valid,
    input  logic [PORT_NUM-1:0]            issue_onehot,
    output logic                           issue_ready,
    input  logic                           rsp_valid,
    input  logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [PORT_NUM-1:0]            port_valid,
    output logic [DATA_WIDTH*PORT_NUM-1:0] port_data,
    output logic [CNT_WIDTH-1:0]           outstanding_cnt,
    output logic                           err_onehot,
    output logic                           err_unexpected
);

    localparam int                   PTR_W  = $clog2(TAG_DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_FULL = CNT_WIDTH'(TAG_DEPTH);

    logic [PORT_NUM-1:0]            r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]               r_wptr;
    logic [PTR_W-1:0]               r_rptr;
    logic [CNT_WIDTH-1:0]           r_cnt;
    logic                           r_alive;
    logic [PORT_NUM-1:0]            r_port_valid;
    logic [DATA_WIDTH*PORT_NUM-1:0] r_port_data;
    logic                           r_err_onehot;
    logic                           r_err_unexpected;

    logic [PORT_NUM-1:0]            w_sel_minus_one;
    logic                           w_sel_onehot;
    logic                           w_issue_ok;
    logic                           w_push;
    logic                           w_pop;
    logic [PORT_NUM-1:0]            w_head;
    logic [DATA_WIDTH*PORT_NUM-1:0] w_lane_data;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_sel_minus_one = issue_onehot - PORT_NUM'(1);
    assign w_sel_onehot    = (|issue_onehot) && !(|(issue_onehot & w_sel_minus_one));

    // r_alive holds issue_ready low until the first clock after reset release.
    assign issue_ready = r_alive && (r_cnt != C_FULL);
    assign w_issue_ok  = issue_valid && issue_ready;
    assign w_push      = w_issue_ok && w_sel_onehot;
    assign w_pop       = rsp_valid && (r_cnt != '0);
    assign w_head      = r_tag_mem[r_rptr];

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_lane
        assign w_lane_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            rsp_data & {DATA_WIDTH{w_pop && w_head[gi]}};
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wptr] <= issue_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_cnt            <= '0;
            r_alive          <= 1'b0;
            r_port_valid     <= '0;
            r_port_data      <= '0;
            r_err_onehot     <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            r_alive          <= 1'b1;
            r_port_valid     <= w_pop ? w_head : '0;
            r_port_data      <= w_lane_data;
            r_err_onehot     <= w_issue_ok && !w_sel_onehot;
            r_err_unexpected <= rsp_valid && (r_cnt == '0);
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_WIDTH'(1);
                2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign port_valid      = r_port_valid;
    assign port_data       = r_port_data;
    assign outstanding_cnt = r_cnt;
    assign err_onehot      = r_err_onehot;
    assign err_unexpected  = r_err_unexpected;

endmodule
`default_nettype wire
